// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART command-assembly stage and the ALU it drives:
// opcode encodings, FSM state encoding and default widths.
package uart_alu_interface_pkg;

  localparam int DBIT_DEF  = 8;
  localparam int NB_OP_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  function automatic logic op_known(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_interface_timeout.sv
// Inter-byte timeout: counts s_tick while a frame is partially assembled and
// strobes expire_o on the tick that reaches TO_TICKS.
module uart_frame_timeout #(
  parameter int TO_TICKS = 16384,
  parameter int TO_W     = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] TERM = TO_W'(TO_TICKS - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expire_o = enable_i && tick_i && (cnt_q == TERM);

  // Outside the timed states the counter is held at zero, which gives the
  // clear-on-entry behaviour without needing next-state knowledge.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i || expire_o) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Assembles A/B/opcode frames from the UART receiver, drives the external ALU
// and hands the latched result to the transmitter with a start/done handshake.
module uart_alu_interface
  import uart_alu_interface_pkg::*;
#(
  parameter int DBIT     = DBIT_DEF,
  parameter int NB_OP    = NB_OP_DEF,
  parameter int TO_TICKS = 16384,
  parameter int TO_W     = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  input  logic             rx_done_tick,
  input  logic [DBIT-1:0]  rx_data,
  input  logic [DBIT-1:0]  alu_result,
  input  logic             tx_done_tick,
  output logic [DBIT-1:0]  alu_a,
  output logic [DBIT-1:0]  alu_b,
  output logic [NB_OP-1:0] alu_op,
  output logic             tx_start,
  output logic [DBIT-1:0]  tx_data,
  output logic             err_tick,
  output logic             busy
);

  state_t           state_q;
  logic [DBIT-1:0]  a_q, b_q, txd_q;
  logic [NB_OP-1:0] op_q;
  logic             start_q, err_q, busy_q;

  logic timed, expire, op_valid;

  assign timed    = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
  assign op_valid = ((rx_data >> NB_OP) == '0) && op_known(6'(rx_data[NB_OP-1:0]));

  uart_frame_timeout #(
    .TO_TICKS (TO_TICKS),
    .TO_W     (TO_W)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (rx_done_tick),
    .enable_i (timed),
    .tick_i   (s_tick),
    .expire_o (expire)
  );

  // A received byte always takes priority over a coincident timeout expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      txd_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_WAIT_A: begin
          if (rx_done_tick) begin
            a_q     <= rx_data;
            state_q <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (rx_done_tick) begin
            b_q     <= rx_data;
            state_q <= ST_WAIT_OP;
          end else if (expire) begin
            err_q   <= 1'b1;
            state_q <= ST_WAIT_A;
          end
        end
        ST_WAIT_OP: begin
          if (rx_done_tick) begin
            if (op_valid) begin
              op_q    <= rx_data[NB_OP-1:0];
              busy_q  <= 1'b1;
              state_q <= ST_EXEC;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_WAIT_A;
            end
          end else if (expire) begin
            err_q   <= 1'b1;
            state_q <= ST_WAIT_A;
          end
        end
        ST_EXEC: begin
          txd_q   <= alu_result;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          start_q <= 1'b1;
          state_q <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (tx_done_tick) begin
            busy_q  <= 1'b0;
            state_q <= ST_WAIT_A;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_WAIT_A;
        end
      endcase
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign tx_data  = txd_q;
  assign tx_start = start_q;
  assign err_tick = err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: a frame-level reference model checked against
// every output each cycle, directed scenarios with literal checks, then random traffic.
module tb_uart_alu_interface;

  localparam int TO_TICKS = 16384;
  localparam logic [5:0] VALID_OPS [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                            6'b100110, 6'b100111, 6'b000011, 6'b000010};

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] alu_result;
  logic       tx_done_tick = 1'b0;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, err_tick, busy;

  int total = 0;
  int bad   = 0;
  bit cmpOn = 1'b0;

  // Reference model state: bytes held in the current frame, stage of the
  // result hand-off (0 none, 1 compute, 2 announce, 3 await transmitter).
  int got = 0, execAge = 0, idle = 0;
  logic [7:0] mA = 0, mB = 0, mTxData = 0;
  logic [5:0] mOp = 0;
  logic       mStart = 0, mErr = 0, mBusy = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] aluRef(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return 8'($signed(a) >>> b);
      6'b000010: return a >> b;
      default:   return 8'h00;
    endcase
  endfunction

  function automatic bit isValidByte(input logic [7:0] d);
    if (d > 8'd63) return 1'b0;
    foreach (VALID_OPS[i]) if (VALID_OPS[i] == d[5:0]) return 1'b1;
    return 1'b0;
  endfunction

  assign alu_result = aluRef(alu_a, alu_b, alu_op);

  uart_alu_interface #(
    .DBIT     (8),
    .NB_OP    (6),
    .TO_TICKS (TO_TICKS),
    .TO_W     (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .alu_result   (alu_result),
    .tx_done_tick (tx_done_tick),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .err_tick     (err_tick),
    .busy         (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rxd, input logic [7:0] d, input bit st, input bit txd);
    rx_done_tick = rxd;
    rx_data      = d;
    s_tick       = st;
    tx_done_tick = txd;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic sendFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    applyStimulus(1'b1, a, 1'b0, 1'b0);
    applyStimulus(1'b1, b, 1'b0, 1'b0);
    applyStimulus(1'b1, op, 1'b0, 1'b0);
  endtask

  // Reference model, evaluated once per clock from the frame-level rules.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        got = 0; execAge = 0; idle = 0;
        mA = 0; mB = 0; mOp = 0; mTxData = 0;
        mStart = 0; mErr = 0; mBusy = 0;
      end else if (clk) begin
        mStart = 0;
        mErr   = 0;
        if (execAge == 1) begin
          mTxData = aluRef(mA, mB, mOp);
          execAge = 2;
        end else if (execAge == 2) begin
          mStart  = 1;
          execAge = 3;
        end else if (execAge == 3) begin
          if (tx_done_tick) begin
            execAge = 0;
            mBusy   = 0;
          end
        end else if (rx_done_tick) begin
          idle = 0;
          if (got == 0) begin
            mA = rx_data; got = 1;
          end else if (got == 1) begin
            mB = rx_data; got = 2;
          end else begin
            got = 0;
            if (isValidByte(rx_data)) begin
              mOp = rx_data[5:0]; execAge = 1; mBusy = 1;
            end else begin
              mErr = 1;
            end
          end
        end else if (got > 0 && s_tick) begin
          if (idle == TO_TICKS - 1) begin
            mErr = 1; got = 0; idle = 0;
          end else begin
            idle++;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cmpOn) begin
        checkOutput("alu_a", alu_a, mA);
        checkOutput("alu_b", alu_b, mB);
        checkOutput("alu_op", alu_op, mOp);
        checkOutput("tx_data", tx_data, mTxData);
        checkOutput("tx_start", tx_start, mStart);
        checkOutput("err_tick", err_tick, mErr);
        checkOutput("busy", busy, mBusy);
      end
    end
  end

  initial begin
    reset = 1'b0;
    @(negedge clk);
    idleCycles(2);
    cmpOn = 1'b1;
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_busy", busy, 0);
    reset = 1'b1;
    idleCycles(2);

    // Clean ADD frame and the two-cycle result latency.
    sendFrame(8'h05, 8'h03, 8'h20);
    checkOutput("add_a", alu_a, 8'h05);
    checkOutput("add_b", alu_b, 8'h03);
    checkOutput("add_op", alu_op, 6'b100000);
    checkOutput("add_busy", busy, 1);
    idleCycles(1);
    checkOutput("add_start_early", tx_start, 0);
    idleCycles(1);
    checkOutput("add_start", tx_start, 1);
    checkOutput("add_txdata", tx_data, 8'h08);
    idleCycles(3);
    checkOutput("add_busy_hold", busy, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("add_busy_done", busy, 0);

    // Invalid opcodes: bad low bits, then an upper bit set.
    sendFrame(8'h10, 8'h01, 8'h3F);
    checkOutput("badlow_err", err_tick, 1);
    checkOutput("badlow_op", alu_op, 6'b100000);
    idleCycles(2);
    checkOutput("badlow_nostart", tx_start, 0);
    sendFrame(8'h10, 8'h01, 8'hA0);
    checkOutput("badhigh_err", err_tick, 1);
    checkOutput("badhigh_busy", busy, 0);
    idleCycles(2);

    // Timeout after a lone byte, then a clean SUB frame.
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < TO_TICKS - 1; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("to_noerr_early", err_tick, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("to_err", err_tick, 1);
    checkOutput("to_stale_a", alu_a, 8'h10);
    sendFrame(8'h02, 8'h02, 8'h22);
    idleCycles(2);
    checkOutput("to_next_start", tx_start, 1);
    checkOutput("to_next_txdata", tx_data, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Byte coincident with the terminal tick in WAIT_B wins.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < TO_TICKS - 1; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("coin_b", alu_b, 8'h55);
    checkOutput("coin_noerr", err_tick, 0);
    applyStimulus(1'b1, 8'h24, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("coin_txdata", tx_data, 8'h11);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Byte arriving while waiting on the transmitter is dropped.
    sendFrame(8'h0C, 8'h0A, 8'h26);
    idleCycles(2);
    checkOutput("xor_txdata", tx_data, 8'h06);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("drop_a", alu_a, 8'h0C);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("drop_busy", busy, 0);
    sendFrame(8'h81, 8'h01, 8'h03);
    idleCycles(2);
    checkOutput("sra_txdata", tx_data, 8'hC0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset pulse while waiting on the transmitter.
    sendFrame(8'h30, 8'h04, 8'h02);
    idleCycles(3);
    reset = 1'b0;
    idleCycles(1);
    checkOutput("midrst_a", alu_a, 0);
    checkOutput("midrst_txdata", tx_data, 0);
    checkOutput("midrst_start", tx_start, 0);
    checkOutput("midrst_busy", busy, 0);
    reset = 1'b1;
    idleCycles(1);
    sendFrame(8'h0F, 8'hF0, 8'h25);
    idleCycles(2);
    checkOutput("postrst_start", tx_start, 1);
    checkOutput("postrst_txdata", tx_data, 8'hFF);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(1, 0) == 1) d = {2'b00, VALID_OPS[$urandom_range(7, 0)]};
      applyStimulus($urandom_range(3, 0) == 0, d, $urandom_range(15, 0) == 0,
                    $urandom_range(7, 0) == 0);
    end
    idleCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
